// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer
//   Issue stage in front of a combinational FPU adder/subtractor
//   (FPU_Arithmatic). Requests (A, B, op) from a valid/ready producer are
//   buffered in a DEPTH-entry FIFO. The FIFO head drives the FPU directly, and
//   the FPU result and flags are captured in an output register that a
//   valid/ready consumer drains in request order. The FIFO and the output
//   register together hold DEPTH+1 requests, and back-to-back throughput is
//   one result per clock.
//
// Optional feature macro: STICKY_FLAGS_EN
//   When defined, sticky overflow/underflow bits are added. Each bit sets when
//   a result carrying that flag is consumed. Both bits clear on reset, on
//   flush or on clr_sticky, and clr_sticky overrides a set on the same edge.
//
// Ports
//   clk, rst_n              clock (rising edge); synchronous active-low reset
//   flush                   synchronous clear of the FIFO and output register
//   in_valid/in_ready       request handshake; in_a, in_b, in_op (0 add, 1 sub)
//   fpu_a/fpu_b/fpu_op      FIFO head to the FPU (all zero when the FIFO is empty)
//   fpu_result/_overflow/_underflow   combinational FPU outputs
//   out_valid/out_ready     result handshake; out_result, out_overflow, out_underflow
//   clr_sticky, sticky_ovf, sticky_unf   only when STICKY_FLAGS_EN is defined
module fpu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
`ifdef STICKY_FLAGS_EN
  input  logic         clr_sticky,
  output logic         sticky_ovf,
  output logic         sticky_unf,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_op,
  output logic [W-1:0] fpu_a,
  output logic [W-1:0] fpu_b,
  output logic         fpu_op,
  input  logic [W-1:0] fpu_result,
  input  logic         fpu_overflow,
  input  logic         fpu_underflow,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_overflow,
  output logic         out_underflow
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

  typedef struct packed {
    logic         op;
    logic [W-1:0] b;
    logic [W-1:0] a;
  } req_t;

  typedef enum logic {S_EMPTY, S_FULL} state_e;

  req_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  state_e        state_q, state_d;
  logic [W-1:0]  res_q;
  logic          ovf_q, unf_q;

  logic          fifo_empty;
  logic          push, load;
  req_t          head;

  assign fifo_empty = (count_q == '0);
  // Depends only on the FIFO count, so there is no combinational path from out_ready.
  assign in_ready   = (count_q != FULL_CNT);
  // A request arriving with flush is discarded.
  assign push       = in_valid & in_ready & ~flush;
  assign head       = mem_q[rd_ptr_q];

  assign fpu_a  = fifo_empty ? '0   : head.a;
  assign fpu_b  = fifo_empty ? '0   : head.b;
  assign fpu_op = fifo_empty ? 1'b0 : head.op;

  // Output register FSM. A load captures the FPU result and pops the head at the same edge.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (!fifo_empty) begin
          state_d = S_FULL;
          load    = 1'b1;
        end
      end
      S_FULL: begin
        if (out_ready) begin
          if (!fifo_empty) load    = 1'b1;
          else             state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, load})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Request storage carries data only; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{op: in_op, b: in_b, a: in_a};
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= S_EMPTY;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (load) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        res_q    <= fpu_result;
        ovf_q    <= fpu_overflow;
        unf_q    <= fpu_underflow;
      end
    end
  end

  assign out_valid     = (state_q == S_FULL);
  assign out_result    = res_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;

`ifdef STICKY_FLAGS_EN
  logic sticky_ovf_q, sticky_unf_q;

  always_ff @(posedge clk) begin
    if (!rst_n || flush || clr_sticky) begin
      sticky_ovf_q <= 1'b0;
      sticky_unf_q <= 1'b0;
    end else if (out_valid && out_ready) begin
      sticky_ovf_q <= sticky_ovf_q | ovf_q;
      sticky_unf_q <= sticky_unf_q | unf_q;
    end
  end

  assign sticky_ovf = sticky_ovf_q;
  assign sticky_unf = sticky_unf_q;
`endif

endmodule
